// File: rtl/dmem_uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter in a 4-word window on the data-memory port.
// Ports: clk, rst (async active-low), rd_addr0/rd_dout0/rd_hit read side,
//        wr_addr0/wr_din0/we0/wr_strb write side, txd serial out, irq_tx_empty level.
module dmem_uart_tx_responder #(
    parameter logic [6:0]  BASE_WORD   = 7'h7C,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  rd_addr0,
    output logic [31:0] rd_dout0,
    output logic        rd_hit,
    input  logic [6:0]  wr_addr0,
    input  logic [31:0] wr_din0,
    input  logic        we0,
    input  logic [2:0]  wr_strb,
    output logic        txd,
    output logic        irq_tx_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, state_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [7:0]    count8;
    logic          fifo_full, fifo_empty;
    logic          overflow;
    logic [15:0]   baud;
    logic [15:0]   d_cur;
    logic [15:0]   timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_end;
    logic          pop, push, drop;
    logic          busy;

    // Offsets wrap mod 128, so anything below BASE_WORD lands far above 3.
    logic [6:0] rd_off, wr_off;
    logic       strb_ok, wr_hit;
    logic       wr_txdata, wr_status, wr_baud;

    logic unused_bits;
    assign unused_bits = ^wr_din0[31:16];

    assign rd_off = rd_addr0 - BASE_WORD;
    assign wr_off = wr_addr0 - BASE_WORD;
    assign rd_hit = (rd_off < 7'd4);

    assign strb_ok = (wr_strb == 3'b000) || (wr_strb == 3'b001) ||
                     (wr_strb == 3'b010);
    assign wr_hit    = we0 && strb_ok && (wr_off < 7'd4);
    assign wr_txdata = wr_hit && (wr_off == 7'd0);
    assign wr_status = wr_hit && (wr_off == 7'd1);
    assign wr_baud   = wr_hit && (wr_off == 7'd2);

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign count8     = 8'(count);

    // Fullness uses the pre-edge count; a same-cycle pop does not make room.
    assign push = wr_txdata && !fifo_full;
    assign drop = wr_txdata && fifo_full;

    assign busy         = (state != IDLE);
    assign irq_tx_empty = fifo_empty && !busy;

    assign d_cur   = (baud == 16'd0) ? 16'd1 : baud;
    assign bit_end = (timer == 16'd0);

    // Read side: purely combinational.
    always_comb begin
        rd_dout0 = 32'd0;
        if (rd_hit) begin
            unique case (rd_off[1:0])
                2'd1: rd_dout0 = {16'd0, count8, 4'd0,
                                  overflow, fifo_empty, fifo_full, busy};
                2'd2: rd_dout0 = {16'd0, baud};
                default: rd_dout0 = 32'd0;
            endcase
        end
    end

    // Config registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud     <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr_baud) begin
                if (wr_strb == 3'b000) baud[7:0] <= wr_din0[7:0];
                else                   baud      <= wr_din0[15:0];
            end
            if (drop)
                overflow <= 1'b1;
            else if (wr_status && wr_din0[3])
                overflow <= 1'b0;
        end
    end

    // FIFO storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_din0[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next state, pop request and serial output.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        txd     = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                txd = shift[0];
                if (bit_end && bit_idx == 3'd7) state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bit timer, bit index and shift register. The divisor is sampled
    // whenever a new bit begins, so BAUDDIV edits land on a bit boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer   <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
        end else if (pop) begin
            shift   <= mem[rptr];
            timer   <= d_cur - 16'd1;
            bit_idx <= 3'd0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                timer <= d_cur - 16'd1;
                if (state == DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                timer <= timer - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_uart_tx_responder.sv
// Randomised self-checking bench for dmem_uart_tx_responder.
// Expected txd waveforms come from a frame-level model (start, 8 data LSB first, stop).
module tb_dmem_uart_tx_responder;

    localparam logic [6:0] BASE = 7'h7C;
    localparam logic [6:0] A_TX = BASE;
    localparam logic [6:0] A_ST = BASE + 7'd1;
    localparam logic [6:0] A_BD = BASE + 7'd2;
    localparam logic [6:0] A_RS = BASE + 7'd3;

    logic        clk;
    logic        rst;
    logic [6:0]  rd_addr0;
    logic [31:0] rd_dout0;
    logic        rd_hit;
    logic [6:0]  wr_addr0;
    logic [31:0] wr_din0;
    logic        we0;
    logic [2:0]  wr_strb;
    logic        txd;
    logic        irq_tx_empty;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    dmem_uart_tx_responder dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr0     (rd_addr0),
        .rd_dout0     (rd_dout0),
        .rd_hit       (rd_hit),
        .wr_addr0     (wr_addr0),
        .wr_din0      (wr_din0),
        .we0          (we0),
        .wr_strb      (wr_strb),
        .txd          (txd),
        .irq_tx_empty (irq_tx_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int effd(input int div);
        return (div == 0) ? 1 : div;
    endfunction

    // One 8N1 frame: slots 0..nb-1 last d0 cycles, the rest d1 cycles.
    function automatic void model_frame(input logic [7:0] b, input int d0,
                                        input int nb, input int d1);
        for (int s = 0; s < 10; s++) begin
            int d;
            bit v;
            d = (s < nb) ? d0 : d1;
            if (s == 0)      v = 1'b0;
            else if (s == 9) v = 1'b1;
            else             v = b[s-1];
            for (int i = 0; i < d; i++) exp_q.push_back(v);
        end
    endfunction

    task automatic do_write(input logic [6:0] a, input logic [31:0] d,
                            input logic [2:0] s);
        wr_addr0 = a;
        wr_din0  = d;
        wr_strb  = s;
        we0      = 1'b1;
        @(posedge clk);
        #1;
        we0 = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b0;
        we0      = 1'b0;
        wr_addr0 = 7'd0;
        wr_din0  = 32'd0;
        wr_strb  = 3'b010;
        rd_addr0 = A_ST;
        #23;
        checks++;
        if (txd !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd_during got %b want 1", txd);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rd_dout0 !== 32'h4 || rd_hit !== 1'b1) begin
            errors++;
            $display("FAIL reset_status got %h hit %b want 00000004 hit 1",
                     rd_dout0, rd_hit);
        end
        rd_addr0 = A_BD;
        #1;
        checks++;
        if (rd_dout0 !== 32'd868) begin
            errors++;
            $display("FAIL reset_bauddiv got %0d want 868", rd_dout0);
        end
        checks++;
        if (txd !== 1'b1 || irq_tx_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle txd %b irq %b want 1 1", txd, irq_tx_empty);
        end
    endtask

    task automatic test_single_frame;
        do_write(A_BD, 32'd4, 3'b010);
        exp_q.delete();
        model_frame(8'hA5, 4, 10, 4);
        rd_addr0 = A_ST;
        do_write(A_TX, 32'h000000A5, 3'b010);
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk);
            #1;
            if (k <= 40) begin
                checks++;
                if (txd !== exp_q[k-1]) begin
                    errors++;
                    $display("FAIL single_txd cycle T+%0d got %b want %b",
                             k, txd, exp_q[k-1]);
                end
            end
            if (k == 1) begin
                checks++;
                if (rd_dout0 !== 32'h5) begin
                    errors++;
                    $display("FAIL single_status_busy got %h want 00000005", rd_dout0);
                end
            end
            if (k == 40) begin
                checks++;
                if (irq_tx_empty !== 1'b0) begin
                    errors++;
                    $display("FAIL single_irq_early got %b want 0", irq_tx_empty);
                end
            end
            if (k == 41) begin
                checks++;
                if (irq_tx_empty !== 1'b1 || rd_dout0 !== 32'h4) begin
                    errors++;
                    $display("FAIL single_idle irq %b status %h want 1 00000004",
                             irq_tx_empty, rd_dout0);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        do_write(A_BD, 32'd2, 3'b010);
        exp_q.delete();
        for (int i = 0; i < 5; i++) model_frame(8'(8'h11 + i), 2, 10, 2);
        rd_addr0 = A_ST;
        wr_addr0 = A_TX;
        wr_strb  = 3'b000;
        wr_din0  = {24'($urandom()), 8'h11};
        we0      = 1'b1;
        for (int k = 0; k <= 101; k++) begin
            @(posedge clk);
            #1;
            if (k < 5) wr_din0 = {24'($urandom()), 8'(8'h12 + k)};
            else       we0 = 1'b0;
            if (k >= 1 && k <= 100) begin
                checks++;
                if (txd !== exp_q[k-1]) begin
                    errors++;
                    $display("FAIL b2b_txd cycle %0d got %b want %b",
                             k, txd, exp_q[k-1]);
                end
            end
            if (k == 5) begin
                checks++;
                if (rd_dout0 !== 32'h0000040B) begin
                    errors++;
                    $display("FAIL b2b_overflow_status got %h want 0000040b", rd_dout0);
                end
            end
            if (k == 100) begin
                checks++;
                if (irq_tx_empty !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_irq_early got %b want 0", irq_tx_empty);
                end
            end
            if (k == 101) begin
                checks++;
                if (irq_tx_empty !== 1'b1 || rd_dout0 !== 32'hC) begin
                    errors++;
                    $display("FAIL b2b_idle irq %b status %h want 1 0000000c",
                             irq_tx_empty, rd_dout0);
                end
            end
        end
        do_write(A_ST, 32'h8, 3'b010);
        checks++;
        if (rd_dout0 !== 32'h4) begin
            errors++;
            $display("FAIL b2b_clear_overflow got %h want 00000004", rd_dout0);
        end
    endtask

    task automatic test_divisor_edges;
        logic [7:0] b;
        do_write(A_BD, 32'hFFFF0000, 3'b010);
        rd_addr0 = A_BD;
        #1;
        checks++;
        if (rd_dout0 !== 32'd0) begin
            errors++;
            $display("FAIL div0_readback got %h want 0", rd_dout0);
        end
        b = 8'($urandom());
        exp_q.delete();
        model_frame(b, 1, 10, 1);
        do_write(A_TX, {24'd0, b}, 3'b000);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (k <= 10) begin
                checks++;
                if (txd !== exp_q[k-1]) begin
                    errors++;
                    $display("FAIL div0_txd cycle %0d got %b want %b",
                             k, txd, exp_q[k-1]);
                end
            end else begin
                checks++;
                if (irq_tx_empty !== 1'b1) begin
                    errors++;
                    $display("FAIL div0_idle got irq %b want 1", irq_tx_empty);
                end
            end
        end
        // 4 -> 8 written during data bit 3 (frame slot 4).
        do_write(A_BD, 32'd4, 3'b010);
        b = 8'($urandom());
        exp_q.delete();
        model_frame(b, 4, 5, 8);
        do_write(A_TX, {24'd0, b}, 3'b001);
        for (int k = 1; k <= 61; k++) begin
            @(posedge clk);
            #1;
            if (k == 17) begin
                wr_addr0 = A_BD;
                wr_din0  = 32'd8;
                wr_strb  = 3'b010;
                we0      = 1'b1;
            end
            if (k == 18) we0 = 1'b0;
            if (k <= 60) begin
                checks++;
                if (txd !== exp_q[k-1]) begin
                    errors++;
                    $display("FAIL divchg_txd cycle %0d got %b want %b",
                             k, txd, exp_q[k-1]);
                end
            end else begin
                checks++;
                if (irq_tx_empty !== 1'b1 || rd_dout0 !== 32'd8) begin
                    errors++;
                    $display("FAIL divchg_end irq %b baud %h want 1 00000008",
                             irq_tx_empty, rd_dout0);
                end
            end
        end
    endtask

    task automatic test_decode;
        logic [6:0] addrs [5];
        logic       hits  [5];
        addrs = '{7'h7B, 7'h00, A_RS, A_TX, 7'h10};
        hits  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rd_addr0 = addrs[i];
            #1;
            checks++;
            if (rd_hit !== hits[i] || rd_dout0 !== 32'd0) begin
                errors++;
                $display("FAIL decode_read addr %h hit %b data %h want %b 0",
                         addrs[i], rd_hit, rd_dout0, hits[i]);
            end
        end
        do_write(A_TX, 32'h55, 3'b011);
        do_write(A_BD, 32'd3, 3'b111);
        do_write(A_RS, 32'hFFFFFFFF, 3'b010);
        rd_addr0 = A_ST;
        #1;
        checks++;
        if (rd_dout0 !== 32'h4) begin
            errors++;
            $display("FAIL decode_bad_strb_push status %h want 00000004", rd_dout0);
        end
        rd_addr0 = A_BD;
        #1;
        checks++;
        if (rd_dout0 !== 32'd8) begin
            errors++;
            $display("FAIL decode_bad_strb_baud got %h want 00000008", rd_dout0);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (txd !== 1'b1) begin
                errors++;
                $display("FAIL decode_no_frame cycle %0d txd %b want 1", k, txd);
            end
        end
    endtask

    task automatic test_random_frames;
        logic [7:0] b [3];
        int div, d, n, len;
        for (int it = 0; it < 8; it++) begin
            div = $urandom_range(0, 3);
            d   = effd(div);
            n   = $urandom_range(1, 3);
            do_write(A_BD, {16'($urandom()), 16'(div)}, 3'b010);
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                b[i] = 8'($urandom());
                model_frame(b[i], d, 10, d);
            end
            len = n * 10 * d;
            wr_addr0 = A_TX;
            wr_strb  = 3'($urandom_range(0, 2));
            wr_din0  = {24'($urandom()), b[0]};
            we0      = 1'b1;
            for (int k = 0; k <= len + 1; k++) begin
                @(posedge clk);
                #1;
                if (k + 1 < n) begin
                    wr_strb = 3'($urandom_range(0, 2));
                    wr_din0 = {24'($urandom()), b[k+1]};
                end else begin
                    we0 = 1'b0;
                end
                if (k >= 1 && k <= len) begin
                    checks++;
                    if (txd !== exp_q[k-1]) begin
                        errors++;
                        $display("FAIL rand_txd it %0d cycle %0d got %b want %b",
                                 it, k, txd, exp_q[k-1]);
                    end
                end
                if (k == len + 1) begin
                    checks++;
                    if (irq_tx_empty !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_idle it %0d irq %b want 1",
                                 it, irq_tx_empty);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        do_write(A_BD, 32'd4, 3'b010);
        rd_addr0 = A_ST;
        do_write(A_TX, 32'h0F, 3'b000);
        do_write(A_TX, 32'hC3, 3'b000);
        do_write(A_TX, 32'h5A, 3'b000);
        // Frame 0 started at cycle 1; data bit 5 spans cycles 25..28.
        for (int k = 3; k <= 26; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (txd !== 1'b0 || rd_dout0 !== 32'h0201) begin
            errors++;
            $display("FAIL midrst_before txd %b status %h want 0 00000201",
                     txd, rd_dout0);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || rd_dout0 !== 32'h4 || irq_tx_empty !== 1'b1) begin
            errors++;
            $display("FAIL midrst_during txd %b status %h irq %b want 1 00000004 1",
                     txd, rd_dout0, irq_tx_empty);
        end
        rst = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (txd !== 1'b1 || irq_tx_empty !== 1'b1) begin
                errors++;
                $display("FAIL midrst_after cycle %0d txd %b irq %b want 1 1",
                         k, txd, irq_tx_empty);
            end
        end
        rd_addr0 = A_BD;
        #1;
        checks++;
        if (rd_dout0 !== 32'd868) begin
            errors++;
            $display("FAIL midrst_bauddiv got %0d want 868", rd_dout0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_divisor_edges();
        test_decode();
        test_random_frames();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_uart_tx_responder.md
Name: dmem_uart_tx_responder

Overview:
Memory-mapped UART transmitter on the CPU data-memory port. It sits beside data_mem on the same rd_addr0/wr_addr0/wr_din0/we0/wr_strb/rd_dout0 interface and claims a 4-word window. Stores into the window push bytes into a TX FIFO, and a baud-timed FSM serialises them 8N1 on txd. Loads return status and config combinationally, which suits the single-cycle core.

Parameters:
BASE_WORD, 7'h7C, word address of register 0; the window is BASE_WORD..BASE_WORD+3 (byte addresses 0x1F0-0x1FF).
FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, at least 2.
DEFAULT_DIV, 16'd868, reset value of BAUDDIV in clk cycles per bit.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low
rd_addr0  in  7  read word address
rd_dout0  out  32  read data; 0 when rd_addr0 is outside the window
rd_hit  out  1  rd_addr0 is inside the window; used by the top-level mux against data_mem
wr_addr0  in  7  write word address
wr_din0  in  32  write data
we0  in  1  write enable
wr_strb  in  3  store funct3: 000 SB, 001 SH, 010 SW; other values are ignored (no write)
txd  out  1  serial output; idles high
irq_tx_empty  out  1  level; 1 when the FIFO is empty and the FSM is IDLE

Behaviour:
- Register map (offset = word address - BASE_WORD):
  - 0 TXDATA: write pushes wr_din0[7:0]; read returns 0.
  - 1 STATUS: read returns {16'b0, count[7:0], 4'b0, overflow, fifo_empty, fifo_full, busy}, with count zero-extended. Writing 1 to bit3 clears overflow; all other write bits are ignored.
  - 2 BAUDDIV: [15:0] read/write; upper bits read 0; writes take the low 16 bits.
  - 3 reserved: reads 0; writes are ignored.
- All writes are accepted only when we0=1, wr_addr0 is in the window, and wr_strb is valid. Byte and half stores write the low lanes of wr_din0.
- Reads are purely combinational, with zero latency.
- Push: a TXDATA write with the FIFO not full enqueues at the clock edge. A TXDATA write with the FIFO full drops the byte and sets the sticky overflow bit. Fullness is judged on the pre-edge count, so a same-cycle pop does not make room.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE with the FIFO non-empty: at the next edge, pop the head into the shift register, go to START, drive txd=0, and load the bit counter.
  - START lasts one bit time, then DATA. DATA sends 8 bits LSB first, each one bit time.
  - STOP drives txd=1 for one bit time. Then the FSM goes to START directly if the FIFO is non-empty, else to IDLE.
- Bit time: each bit lasts D cycles, where D = BAUDDIV, or 1 if BAUDDIV = 0. D is sampled at the start of every bit, so a mid-frame BAUDDIV write affects the next bit boundary only.
- Latency: a TXDATA push at edge T into an empty FIFO with the FSM IDLE gives txd falling at edge T+1.
- busy = (state != IDLE). Pop and push in the same cycle are both honoured; count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Reset (asynchronous, any time including mid-frame):
  - txd=1, state IDLE, FIFO emptied (count=0), overflow=0, BAUDDIV=DEFAULT_DIV.
  - Therefore irq_tx_empty=1, and a STATUS read returns 0x00000004.
  - A partial frame is abandoned with no completion.

Test Plan:
- Reset readback: rst low then high; read STATUS -> 0x00000004 and BAUDDIV -> 868; txd=1; irq_tx_empty=1.
- Single frame: write BAUDDIV=4, then SW 0x000000A5 to TXDATA at edge T. Required response:
  - txd=0 during cycles T+1..T+4.
  - Then bits 1,0,1,0,0,1,0,1, 4 cycles each.
  - Then txd=1 for 4 cycles; IDLE at T+41; irq_tx_empty rises at T+41.
- Back-to-back and overflow: with BAUDDIV=2, issue 6 SB writes of 0x11..0x16 on consecutive cycles. Required response:
  - 0x11 pops after 1 cycle; 0x12-0x15 fill the FIFO; 0x16 is dropped.
  - STATUS shows overflow=1 and count=4.
  - Five frames follow with no idle gap between STOP and START.
  - Writing STATUS=0x8 clears overflow.
- Divisor edge cases: BAUDDIV=0 gives 1-cycle bits, 10 cycles per frame. Writing BAUDDIV from 4 to 8 during DATA bit 3 keeps bit 3 at 4 cycles and makes bit 4 onward 8 cycles.
- Decode and strobe: reads at BASE_WORD-1 and BASE_WORD+4 give rd_hit=0 and rd_dout0=0. A write with wr_strb=3'b011 to TXDATA does not push, and count stays 0. Reads of offset 3 return 0.
- Reset mid-frame: assert rst during DATA bit 5 with 2 entries queued. txd goes 1 immediately, count=0, and after release there is no further start bit.
